// File: rtl/jedro_1_decoder_pkg.sv
// jedro_1_decoder_pkg
//   Shared constants and types for the jedro_1 decode stage: ALU op codes,
//   RV32I opcode/funct3/funct7 encodings, the decoded bundle that travels
//   through the skid buffer, and the skid FSM state type.
//   Optional feature macro: DECODER_ILLEGAL_TRAP_EN adds an 'illegal' flag
//   to the decoded bundle.
package jedro_1_decoder_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int ALU_OP_WIDTH = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd9;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0] op;
        logic [DATA_WIDTH-1:0]   opa;
        logic [DATA_WIDTH-1:0]   opb;
        logic [4:0]              rd;
        logic                    rd_we;
`ifdef DECODER_ILLEGAL_TRAP_EN
        logic                    illegal;
`endif
    } dec_bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // funct3 -> ALU op; 'alt' selects SUB/SRA for the two funct3 codes
    // that have an alternate encoding.
    function automatic logic [ALU_OP_WIDTH-1:0] f3_to_alu_op(input logic [2:0] f3,
                                                             input logic       alt);
        logic [ALU_OP_WIDTH-1:0] op;
        op = ALU_OP_ADD;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_OP_SUB : ALU_OP_ADD;
            F3_SLL:     op = ALU_OP_SLL;
            F3_SLT:     op = ALU_OP_SLT;
            F3_SLTU:    op = ALU_OP_SLTU;
            F3_XOR:     op = ALU_OP_XOR;
            F3_SRL_SRA: op = alt ? ALU_OP_SRA : ALU_OP_SRL;
            F3_OR:      op = ALU_OP_OR;
            F3_AND:     op = ALU_OP_AND;
            default:    op = ALU_OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/jedro_1_decoder_comb.sv
// jedro_1_decoder_comb
//   Pure combinational RV32I decode of OP, OP-IMM and LUI into an ALU bundle.
//   Anything else (or a bad funct7 / shift imm[11:5]) becomes a NOP beat:
//   ADD 0,0 with rd=0 and rd_we=0 (flagged when DECODER_ILLEGAL_TRAP_EN).
//   Ports:
//     instr_i      instruction word
//     rf_data_a_i  rs1 value
//     rf_data_b_i  rs2 value
//     dec_o        decoded bundle
module jedro_1_decoder_comb
    import jedro_1_decoder_pkg::*;
(
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] rf_data_a_i,
    input  logic [DATA_WIDTH-1:0] rf_data_b_i,
    output dec_bundle_t           dec_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    logic                    legal;
    logic                    alt;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [DATA_WIDTH-1:0]   opa;
    logic [DATA_WIDTH-1:0]   opb;

    always_comb begin
        legal = 1'b0;
        alt   = 1'b0;
        op    = ALU_OP_ADD;
        opa   = rf_data_a_i;
        opb   = rf_data_b_i;
        case (opcode)
            OPCODE_OP: begin
                // Only ADD/SUB and SRL/SRA have a second funct7 encoding.
                alt   = (f7 == F7_ALT) && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA);
                legal = (f7 == F7_BASE) || alt;
                op    = f3_to_alu_op(f3, alt);
            end
            OPCODE_OP_IMM: begin
                opb = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
                if (f3 == F3_SLL || f3 == F3_SRL_SRA) begin
                    // Shift-immediates reuse imm[11:5] as a funct7 field.
                    alt   = (f7 == F7_ALT) && (f3 == F3_SRL_SRA);
                    legal = (f7 == F7_BASE) || alt;
                    opb   = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};
                end else begin
                    legal = 1'b1;
                end
                op = f3_to_alu_op(f3, alt);
            end
            OPCODE_LUI: begin
                legal = 1'b1;
                opa   = '0;
                opb   = {instr_i[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_o = '0;
        if (legal) begin
            dec_o.op    = op;
            dec_o.opa   = opa;
            dec_o.opb   = opb;
            dec_o.rd    = rd;
            dec_o.rd_we = (rd != 5'd0);
        end
`ifdef DECODER_ILLEGAL_TRAP_EN
        dec_o.illegal = ~legal;
`endif
    end

endmodule

// File: rtl/jedro_1_decoder.sv
// jedro_1_decoder
//   Decode stage of jedro_1: decodes the incoming instruction (with same-cycle
//   register-file read data) and buffers the result in a 2-entry skid buffer
//   (head + skid register) feeding the ALU.
//   Optional feature macro: DECODER_ILLEGAL_TRAP_EN adds the illegal_o port.
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     flush_i                      drop buffered and same-cycle incoming beats
//     instr_i/_valid_i/ready_o     fetch-side handshake (ready registered)
//     rf_addr_a_o/b_o              rs1/rs2 register-file addresses (comb)
//     rf_data_a_i/b_i              register-file read data, same cycle
//     alu_valid_o/alu_ready_i      ALU-side handshake
//     alu_op_sel_o/opa_o/opb_o     ALU op and operands from the head entry
//     rd_addr_o/rd_we_o            destination register and write enable
//     illegal_o                    unsupported encoding (optional)
module jedro_1_decoder
    import jedro_1_decoder_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [31:0]             instr_i,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    output logic [4:0]              rf_addr_a_o,
    output logic [4:0]              rf_addr_b_o,
    input  logic [DATA_WIDTH-1:0]   rf_data_a_i,
    input  logic [DATA_WIDTH-1:0]   rf_data_b_i,
    output logic                    alu_valid_o,
    input  logic                    alu_ready_i,
    output logic [ALU_OP_WIDTH-1:0] alu_op_sel_o,
    output logic [DATA_WIDTH-1:0]   alu_opa_o,
    output logic [DATA_WIDTH-1:0]   alu_opb_o,
    output logic [4:0]              rd_addr_o,
    output logic                    rd_we_o
`ifdef DECODER_ILLEGAL_TRAP_EN
    ,
    output logic                    illegal_o
`endif
);

    assign rf_addr_a_o = instr_i[19:15];
    assign rf_addr_b_o = instr_i[24:20];

    dec_bundle_t dec;

    jedro_1_decoder_comb u_comb (
        .instr_i     (instr_i),
        .rf_data_a_i (rf_data_a_i),
        .rf_data_b_i (rf_data_b_i),
        .dec_o       (dec)
    );

    skid_state_t state;
    dec_bundle_t head_q;
    dec_bundle_t skid_q;
    logic        ready_q;
    logic        valid_q;

    logic accept;
    logic out;

    assign accept = instr_valid_i & ready_q;
    assign out    = valid_q & alu_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            head_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            // The same-cycle input beat is dropped simply by not capturing it.
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head_q  <= dec;
                        valid_q <= 1'b1;
                        state   <= ST_HALF;
                    end
                end
                ST_HALF: begin
                    case ({accept, out})
                        2'b10: begin
                            skid_q  <= dec;
                            ready_q <= 1'b0;
                            state   <= ST_FULL;
                        end
                        2'b01: begin
                            valid_q <= 1'b0;
                            state   <= ST_EMPTY;
                        end
                        2'b11:   head_q <= dec;
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    // ready_q is low here, so no accept can coincide.
                    if (out) begin
                        head_q  <= skid_q;
                        ready_q <= 1'b1;
                        state   <= ST_HALF;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready_o = ready_q;
    assign alu_valid_o   = valid_q;
    assign alu_op_sel_o  = head_q.op;
    assign alu_opa_o     = head_q.opa;
    assign alu_opb_o     = head_q.opb;
    assign rd_addr_o     = head_q.rd;
    assign rd_we_o       = head_q.rd_we;
`ifdef DECODER_ILLEGAL_TRAP_EN
    assign illegal_o     = head_q.illegal;
`endif

endmodule

// File: tb/tb_jedro_1_decoder.sv
// tb_jedro_1_decoder
//   Table of decode vectors with hand-computed results, followed by directed
//   sequences for back-pressure ordering, flush (FULL and HALF) and reset
//   mid-transfer. Build with DECODER_ILLEGAL_TRAP_EN to also check illegal_o.
module tb_jedro_1_decoder;
    import jedro_1_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [4:0]  rf_addr_a_o, rf_addr_b_o;
    logic [31:0] rf_data_a_i = '0, rf_data_b_i = '0;
    logic        alu_valid_o;
    logic        alu_ready_i = 1'b1;
    logic [3:0]  alu_op_sel_o;
    logic [31:0] alu_opa_o, alu_opb_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o;
`ifdef DECODER_ILLEGAL_TRAP_EN
    logic        illegal_o;
`endif

    jedro_1_decoder dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .rf_addr_a_o   (rf_addr_a_o),
        .rf_addr_b_o   (rf_addr_b_o),
        .rf_data_a_i   (rf_data_a_i),
        .rf_data_b_i   (rf_data_b_i),
        .alu_valid_o   (alu_valid_o),
        .alu_ready_i   (alu_ready_i),
        .alu_op_sel_o  (alu_op_sel_o),
        .alu_opa_o     (alu_opa_o),
        .alu_opb_o     (alu_opb_o),
        .rd_addr_o     (rd_addr_o),
        .rd_we_o       (rd_we_o)
`ifdef DECODER_ILLEGAL_TRAP_EN
        ,
        .illegal_o     (illegal_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Every beat handed to the ALU side, identified by operand A.
    logic [31:0] got[$];
    always @(posedge clk)
        if (!rst_i && alu_valid_o && alu_ready_i) got.push_back(alu_opa_o);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Present one beat and hold it until accepted; returns #1 after the
    // accepting edge with instr_i still driven.
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        instr_i = ins; rf_data_a_i = a; rf_data_b_i = b; instr_valid_i = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (instr_ready_o) ok = 1'b1;
            @(posedge clk);
            if (!ok) @(negedge clk);
        end
        #1 instr_valid_i = 1'b0;
        chk("send_accept", {31'b0, ok}, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr, a, b;
        logic [4:0]  ra, rb;
        logic [3:0]  op;
        logic [31:0] opa, opb;
        logic [4:0]  rd;
        logic        we, ill;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic [31:0] ins, a, b, input logic [4:0] ra, rb,
                       input logic [3:0] op, input logic [31:0] opa, opb,
                       input logic [4:0] rd, input logic we, ill);
        vec_t v;
        v.name = nm; v.instr = ins; v.a = a; v.b = b; v.ra = ra; v.rb = rb;
        v.op = op; v.opa = opa; v.opb = opb; v.rd = rd; v.we = we; v.ill = ill;
        vq.push_back(v);
    endtask

    localparam logic [31:0] ADD_X3 = 32'h002081B3;

    initial begin
        //   name      instr          a             b            ra  rb  op           opa           opb           rd we ill
        add("add",     32'h002081B3, 32'd5,        32'd3,       1,  2,  ALU_OP_ADD,  32'd5,        32'd3,        3, 1, 0);
        add("addi",    32'hFFF00093, 32'd0,        32'h77,      0,  31, ALU_OP_ADD,  32'd0,        32'hFFFFFFFF, 1, 1, 0);
        add("sub",     32'h402081B3, 32'd5,        32'd3,       1,  2,  ALU_OP_SUB,  32'd5,        32'd3,        3, 1, 0);
        add("srai",    32'h40435293, 32'h80000000, 32'h99,      6,  4,  ALU_OP_SRA,  32'h80000000, 32'd4,        5, 1, 0);
        add("lui",     32'h123453B7, 32'hDEAD,     32'hBEEF,    8,  3,  ALU_OP_ADD,  32'd0,        32'h12345000, 7, 1, 0);
        add("zero",    32'h00000000, 32'h11,       32'h22,      0,  0,  ALU_OP_ADD,  32'd0,        32'd0,        0, 0, 1);
        add("bad_f7",  32'h022081B3, 32'd5,        32'd3,       1,  2,  ALU_OP_ADD,  32'd0,        32'd0,        0, 0, 1);
        add("slli31",  32'h01F11093, 32'hAA,       32'hBB,      2,  31, ALU_OP_SLL,  32'hAA,       32'd31,       1, 1, 0);
        add("add_x0",  32'h00208033, 32'd5,        32'd3,       1,  2,  ALU_OP_ADD,  32'd5,        32'd3,        0, 0, 0);
        add("sltu",    32'h0020B233, 32'd7,        32'd9,       1,  2,  ALU_OP_SLTU, 32'd7,        32'd9,        4, 1, 0);
        add("andi",    32'h7FF4F413, 32'h1234,     32'd0,       9,  31, ALU_OP_AND,  32'h1234,     32'h7FF,      8, 1, 0);
        add("bad_slli",32'h40111093, 32'd1,        32'd2,       2,  1,  ALU_OP_ADD,  32'd0,        32'd0,        0, 0, 1);
        add("sra",     32'h4020D1B3, 32'hF0,       32'd2,       1,  2,  ALU_OP_SRA,  32'hF0,       32'd2,        3, 1, 0);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        chk("rst_ready", {31'b0, instr_ready_o}, 32'd1);
        chk("rst_valid", {31'b0, alu_valid_o},   32'd0);
        chk("rst_op",    {28'b0, alu_op_sel_o},  {28'b0, ALU_OP_ADD});
        chk("rst_opa",   alu_opa_o, 32'd0);
        chk("rst_opb",   alu_opb_o, 32'd0);
        chk("rst_rd",    {27'b0, rd_addr_o}, 32'd0);
        chk("rst_we",    {31'b0, rd_we_o},   32'd0);
`ifdef DECODER_ILLEGAL_TRAP_EN
        chk("rst_ill",   {31'b0, illegal_o}, 32'd0);
`endif

        // Decode table; one-cycle latency means fields are visible right
        // after the accepting edge.
        foreach (vq[i]) begin
            send(vq[i].instr, vq[i].a, vq[i].b);
            chk({vq[i].name, "_ra"},    {27'b0, rf_addr_a_o},  {27'b0, vq[i].ra});
            chk({vq[i].name, "_rb"},    {27'b0, rf_addr_b_o},  {27'b0, vq[i].rb});
            chk({vq[i].name, "_valid"}, {31'b0, alu_valid_o},  32'd1);
            chk({vq[i].name, "_op"},    {28'b0, alu_op_sel_o}, {28'b0, vq[i].op});
            chk({vq[i].name, "_opa"},   alu_opa_o, vq[i].opa);
            chk({vq[i].name, "_opb"},   alu_opb_o, vq[i].opb);
            chk({vq[i].name, "_we"},    {31'b0, rd_we_o}, {31'b0, vq[i].we});
            if (!vq[i].ill) chk({vq[i].name, "_rd"}, {27'b0, rd_addr_o}, {27'b0, vq[i].rd});
`ifdef DECODER_ILLEGAL_TRAP_EN
            chk({vq[i].name, "_ill"},   {31'b0, illegal_o}, {31'b0, vq[i].ill});
`endif
        end
        repeat (3) @(negedge clk);
        chk("drain_valid", {31'b0, alu_valid_o}, 32'd0);
        chk("table_beats", got.size(), vq.size());

        // Back-pressure: 3 beats while ALU stalls; order preserved.
        got.delete();
        alu_ready_i = 1'b0;
        send(ADD_X3, 32'd11, 32'd0);
        send(ADD_X3, 32'd22, 32'd0);
        chk("bp_ready_full", {31'b0, instr_ready_o}, 32'd0);
        @(negedge clk);
        instr_i = ADD_X3; rf_data_a_i = 32'd33; instr_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_ready_hold", {31'b0, instr_ready_o}, 32'd0);
        chk("bp_head_stable", alu_opa_o, 32'd11);
        chk("bp_no_out", got.size(), 32'd0);
        alu_ready_i = 1'b1;
        send(ADD_X3, 32'd33, 32'd0);
        repeat (4) @(negedge clk);
        chk("bp_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            chk("bp_beat1", got[0], 32'd11);
            chk("bp_beat2", got[1], 32'd22);
            chk("bp_beat3", got[2], 32'd33);
        end

        // Flush from FULL with an incoming beat present.
        got.delete();
        alu_ready_i = 1'b0;
        send(ADD_X3, 32'd44, 32'd0);
        send(ADD_X3, 32'd55, 32'd0);
        chk("fl_full_ready", {31'b0, instr_ready_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b1; rf_data_a_i = 32'd66; instr_valid_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; instr_valid_i = 1'b0;
        chk("fl_full_valid", {31'b0, alu_valid_o},   32'd0);
        chk("fl_full_ready1", {31'b0, instr_ready_o}, 32'd1);
        alu_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("fl_full_dropped", got.size(), 32'd0);

        // Flush from HALF while an accepted-looking beat arrives.
        alu_ready_i = 1'b0;
        send(ADD_X3, 32'd77, 32'd0);
        @(negedge clk);
        flush_i = 1'b1; rf_data_a_i = 32'd88; instr_valid_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; instr_valid_i = 1'b0;
        chk("fl_half_valid", {31'b0, alu_valid_o}, 32'd0);
        alu_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("fl_half_dropped", got.size(), 32'd0);

        // Reset mid-transfer discards everything.
        alu_ready_i = 1'b0;
        send(ADD_X3, 32'd99, 32'd0);
        send(ADD_X3, 32'd100, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("mid_rst_valid", {31'b0, alu_valid_o},   32'd0);
        chk("mid_rst_ready", {31'b0, instr_ready_o}, 32'd1);
        chk("mid_rst_opa",   alu_opa_o, 32'd0);
        chk("mid_rst_we",    {31'b0, rd_we_o}, 32'd0);
        alu_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_dropped", got.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
